// File: rtl/blitstop_mc_if.sv
// Blitter stop/collision controller bus: GPU register access plus
// per-channel write/inhibit lines and the controller's outputs.
interface blitstop_mc_if #(
    parameter int NCH = 2
);
    logic [31:0]    gpu_din;
    logic           stopld;
    logic           statrd;
    logic [NCH-1:0] dwrite;
    logic [NCH-1:0] nowrite;
    logic           stopped;
    logic           reset_n;
    logic [31:0]    gpu_dout;
    logic           gpu_dout_oe;

    modport master (
        output gpu_din, stopld, statrd, dwrite, nowrite,
        input  stopped, reset_n, gpu_dout, gpu_dout_oe
    );

    modport slave (
        input  gpu_din, stopld, statrd, dwrite, nowrite,
        output stopped, reset_n, gpu_dout, gpu_dout_oe
    );
endinterface

// File: rtl/blitstop_mc.sv
// Blitter collision stop controller: IDLE/STOPPED/RESET FSM with status.
// Optional saturating collision counter under BLITSTOP_COLLCNT_EN.
module blitstop_mc #(
    parameter int NCH    = 2,
    parameter int RSTLEN = 1,
    parameter int CNTW   = 8
) (
    input  logic          clk_0,
    input  logic          xreset,
    blitstop_mc_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STOP = 2'd1;
    localparam logic [1:0] S_RST  = 2'd2;
    localparam logic [3:0] RST_INIT = 4'(RSTLEN - 1);

    logic [1:0]     state_q, state_d;
    logic [NCH-1:0] stopen_q, stopen_d;
    logic [NCH-1:0] collb_q;
    logic [NCH-1:0] pend_q, pend_d;
    logic [2:0]     chan_q, chan_d;
    logic [3:0]     rcnt_q, rcnt_d;
    logic           stopped_q;
    logic [NCH-1:0] collidea, collide;
    logic [2:0]     low_ch;
    logic           go_stop;
    logic [CNTW-1:0] ccnt_q;
    logic [31:0]    dout;
    logic           unused_din;

    assign unused_din = ^bus.gpu_din;
    assign collidea = bus.nowrite & bus.dwrite & stopen_q;
    assign collide  = collidea & ~collb_q;

    always_comb begin
        low_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (collide[i]) low_ch = 3'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        chan_d   = chan_q;
        rcnt_d   = rcnt_q;
        go_stop  = 1'b0;
        stopen_d = bus.stopld ? bus.gpu_din[8+:NCH] : stopen_q;
        case (state_q)
            S_IDLE: begin
                // a collision beats any resume/abort bits in the same write
                if (|collide) begin
                    state_d = S_STOP;
                    chan_d  = low_ch;
                    pend_d  = collide;
                    go_stop = 1'b1;
                end
            end
            S_STOP: begin
                if (bus.stopld && bus.gpu_din[1]) begin
                    state_d = S_RST;
                    rcnt_d  = RST_INIT;
                end else if (bus.stopld && bus.gpu_din[0]) begin
                    state_d = S_IDLE;
                end else begin
                    pend_d = pend_q | collide;
                end
            end
            S_RST: begin
                if (rcnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    pend_d  = '0;
                    chan_d  = '0;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (xreset) begin
            state_q   <= S_IDLE;
            stopen_q  <= '0;
            collb_q   <= '0;
            pend_q    <= '0;
            chan_q    <= '0;
            rcnt_q    <= '0;
            stopped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stopen_q  <= stopen_d;
            collb_q   <= collidea;
            pend_q    <= pend_d;
            chan_q    <= chan_d;
            rcnt_q    <= rcnt_d;
            stopped_q <= (state_d == S_STOP);
        end
    end

`ifdef BLITSTOP_COLLCNT_EN
    logic [CNTW-1:0] ccnt_d;

    always_comb begin
        ccnt_d = ccnt_q;
        if (bus.stopld && bus.gpu_din[3]) begin
            ccnt_d = '0;
        end else if (go_stop && (ccnt_q != '1)) begin
            ccnt_d = ccnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk_0) begin
        if (xreset) ccnt_q <= '0;
        else        ccnt_q <= ccnt_d;
    end
`else
    logic unused_go;
    assign unused_go = go_stop;
    assign ccnt_q    = '0;
`endif

    always_comb begin
        dout = '0;
        if (bus.statrd) begin
            dout[1]        = stopped_q;
            dout[2]        = (state_q == S_RST);
            dout[6:4]      = chan_q;
            dout[8+:NCH]   = pend_q;
            dout[16+:CNTW] = ccnt_q;
        end
    end

    assign bus.stopped     = stopped_q;
    assign bus.reset_n     = ~(xreset | (state_q == S_RST));
    assign bus.gpu_dout    = dout;
    assign bus.gpu_dout_oe = bus.statrd;
endmodule

// File: tb/tb_blitstop_mc.sv
// Directed bench for blitstop_mc: vector table on a 2-channel instance
// plus hand sequences for saturation, xreset and a 4-channel instance.
module tb_blitstop_mc;
    logic clk_0 = 1'b0;
    logic xreset;
    int   total = 0;
    int   bad   = 0;

`ifdef BLITSTOP_COLLCNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    always #5 clk_0 = ~clk_0;

    blitstop_mc_if #(.NCH(2)) b2 ();
    blitstop_mc_if #(.NCH(4)) b4 ();

    blitstop_mc #(.NCH(2), .RSTLEN(3), .CNTW(2)) u2 (
        .clk_0 (clk_0),
        .xreset(xreset),
        .bus   (b2.slave)
    );

    blitstop_mc #(.NCH(4), .RSTLEN(1), .CNTW(8)) u4 (
        .clk_0 (clk_0),
        .xreset(xreset),
        .bus   (b4.slave)
    );

    typedef struct {
        string       nm;
        logic        ld;
        logic [31:0] din;
        logic        rd;
        logic [1:0]  dw;
        logic [1:0]  nw;
        logic        e_stp;
        logic        e_rn;
        logic [31:0] e_do;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] st(logic s, logic r, logic [2:0] ch,
                                       logic [7:0] pend, logic [15:0] cnt);
        logic [31:0] v;
        v        = '0;
        v[1]     = s;
        v[2]     = r;
        v[6:4]   = ch;
        v[15:8]  = pend;
        v[31:16] = CE ? cnt : 16'h0;
        return v;
    endfunction

    function automatic vec_t mk(string nm, logic ld, logic [31:0] din,
                                logic rd, logic [1:0] dw, logic [1:0] nw,
                                logic stp, logic rn, logic [31:0] d);
        vec_t v;
        v.nm = nm; v.ld = ld; v.din = din; v.rd = rd;
        v.dw = dw; v.nw = nw; v.e_stp = stp; v.e_rn = rn; v.e_do = d;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk_0);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drv2(logic ld, logic [31:0] din, logic [1:0] c);
        b2.stopld  = ld;
        b2.gpu_din = din;
        b2.dwrite  = c;
        b2.nowrite = c;
    endtask

    initial begin
        xreset = 1'b1;
        b2.gpu_din = '0; b2.stopld = 1'b0; b2.statrd = 1'b1;
        b2.dwrite = '0;  b2.nowrite = '0;
        b4.gpu_din = '0; b4.stopld = 1'b0; b4.statrd = 1'b1;
        b4.dwrite = '0;  b4.nowrite = '0;

        tv.push_back(mk("ld_en",    1, 32'h200, 1, 2'b00, 2'b00, 0, 1, st(0,0,0,0,0)));
        tv.push_back(mk("dw_only",  0, 32'h0,   1, 2'b10, 2'b00, 0, 1, st(0,0,0,0,0)));
        tv.push_back(mk("rise1",    0, 32'h0,   1, 2'b10, 2'b10, 1, 1, st(1,0,1,2,1)));
        tv.push_back(mk("hold1",    0, 32'h0,   1, 2'b10, 2'b10, 1, 1, st(1,0,1,2,1)));
        tv.push_back(mk("resume",   1, 32'h201, 1, 2'b10, 2'b10, 0, 1, st(0,0,1,2,1)));
        tv.push_back(mk("no_retrig",0, 32'h0,   1, 2'b10, 2'b10, 0, 1, st(0,0,1,2,1)));
        tv.push_back(mk("drop",     0, 32'h0,   1, 2'b00, 2'b00, 0, 1, st(0,0,1,2,1)));
        tv.push_back(mk("idle_res", 1, 32'h1,   1, 2'b00, 2'b00, 0, 1, st(0,0,1,2,1)));
        tv.push_back(mk("idle_abt", 1, 32'h2,   1, 2'b00, 2'b00, 0, 1, st(0,0,1,2,1)));
        tv.push_back(mk("en_off",   0, 32'h0,   1, 2'b10, 2'b10, 0, 1, st(0,0,1,2,1)));
        tv.push_back(mk("reload",   1, 32'h200, 1, 2'b10, 2'b10, 0, 1, st(0,0,1,2,1)));
        tv.push_back(mk("rise2",    0, 32'h0,   1, 2'b10, 2'b10, 1, 1, st(1,0,1,2,2)));
        tv.push_back(mk("abort",    1, 32'h3,   1, 2'b00, 2'b00, 0, 0, st(0,1,1,2,2)));
        tv.push_back(mk("rst2",     1, 32'h200, 1, 2'b00, 2'b00, 0, 0, st(0,1,1,2,2)));
        tv.push_back(mk("rst3_coll",0, 32'h0,   1, 2'b10, 2'b10, 0, 0, st(0,1,1,2,2)));
        tv.push_back(mk("rst_exit", 0, 32'h0,   1, 2'b10, 2'b10, 0, 1, st(0,0,0,0,2)));
        tv.push_back(mk("rd_off",   0, 32'h0,   0, 2'b00, 2'b00, 0, 1, 32'h0));
        tv.push_back(mk("coll_ld",  1, 32'h203, 1, 2'b10, 2'b10, 1, 1, st(1,0,1,2,3)));
        tv.push_back(mk("resume2",  1, 32'h201, 1, 2'b00, 2'b00, 0, 1, st(0,0,1,2,3)));

        tick;
        tick;
        chk("rst_rn_low", 32'(b2.reset_n), 32'h0);
        xreset = 1'b0;
        #1;
        chk("rst_rn_rel", 32'(b2.reset_n), 32'h1);
        tick;
        chk("rst_stp", 32'(b2.stopped), 32'h0);
        chk("rst_dout", b2.gpu_dout, 32'h0);

        foreach (tv[k]) begin
            drv2(tv[k].ld, tv[k].din, 2'b00);
            b2.dwrite  = tv[k].dw;
            b2.nowrite = tv[k].nw;
            b2.statrd  = tv[k].rd;
            tick;
            chk($sformatf("%s.stp", tv[k].nm), 32'(b2.stopped), 32'(tv[k].e_stp));
            chk($sformatf("%s.rn", tv[k].nm), 32'(b2.reset_n), 32'(tv[k].e_rn));
            chk($sformatf("%s.dout", tv[k].nm), b2.gpu_dout, tv[k].e_do);
            chk($sformatf("%s.oe", tv[k].nm), 32'(b2.gpu_dout_oe), 32'(tv[k].rd));
        end
        b2.statrd = 1'b1;

        for (int n = 0; n < 2; n++) begin
            drv2(1'b0, 32'h0, 2'b10);
            tick;
            chk("sat_stop", 32'(b2.stopped), 32'h1);
            drv2(1'b1, 32'h201, 2'b00);
            tick;
            chk("sat_resume", 32'(b2.stopped), 32'h0);
        end
        chk("sat_cnt", b2.gpu_dout, st(0,0,1,2,3));
        drv2(1'b1, 32'h8, 2'b00);
        tick;
        chk("cnt_clr", b2.gpu_dout, st(0,0,1,2,0));

        drv2(1'b1, 32'h200, 2'b00);
        tick;
        drv2(1'b0, 32'h0, 2'b10);
        tick;
        chk("xr_stop", 32'(b2.stopped), 32'h1);
        drv2(1'b1, 32'h202, 2'b00);
        tick;
        chk("xr_inrst", b2.gpu_dout, st(0,1,1,2,1));
        drv2(1'b0, 32'h0, 2'b00);
        xreset = 1'b1;
        tick;
        chk("xr_rn", 32'(b2.reset_n), 32'h0);
        chk("xr_dout", b2.gpu_dout, 32'h0);
        xreset = 1'b0;
        #1;
        chk("xr_rn_rel", 32'(b2.reset_n), 32'h1);
        drv2(1'b0, 32'h0, 2'b10);
        tick;
        chk("xr_en_clr", 32'(b2.stopped), 32'h0);
        drv2(1'b0, 32'h0, 2'b00);

        b4.stopld = 1'b1; b4.gpu_din = 32'hF00;
        tick;
        b4.stopld = 1'b0; b4.gpu_din = 32'h0;
        b4.dwrite = 4'b0101; b4.nowrite = 4'b0101;
        tick;
        chk("c4_stop", 32'(b4.stopped), 32'h1);
        chk("c4_dual", b4.gpu_dout, st(1,0,0,8'h05,1));
        b4.dwrite = 4'b1101; b4.nowrite = 4'b1101;
        tick;
        chk("c4_or", b4.gpu_dout, st(1,0,0,8'h0D,1));
        b4.dwrite = 4'b0; b4.nowrite = 4'b0;
        b4.stopld = 1'b1; b4.gpu_din = 32'h2;
        tick;
        b4.stopld = 1'b0; b4.gpu_din = 32'h0;
        chk("c4_rn0", 32'(b4.reset_n), 32'h0);
        chk("c4_rst", b4.gpu_dout, st(0,1,0,8'h0D,1));
        tick;
        chk("c4_rn1", 32'(b4.reset_n), 32'h1);
        chk("c4_idle", b4.gpu_dout, st(0,0,0,0,1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
